// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined core's memory path: RAM handshake state,
// data word, and the memory arbiter's grant-state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t IGNT = 2'd1;
  localparam arb_state_t DGNT = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: arb is the arbiter's view,
// tb is the requester/RAM-model view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import cpu_types_pkg::*;

  logic              CLK;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;
  logic              mem_err;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport tb (
    output CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

endinterface

// File: rtl/arb_stats.sv
// Completion and stall counters for mem_arbiter; only built when
// MEM_ARB_STATS_EN is defined. All counters wrap mod 2^32.
`ifdef MEM_ARB_STATS_EN
module arb_stats (
  input  logic        CLK,
  input  logic        RST,
  input  logic        icomp,
  input  logic        dcomp,
  input  logic        stall,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount   <= '0;
      dcount   <= '0;
      stallcnt <= '0;
    end else begin
      if (icomp) icount   <= icount + 32'd1;
      if (dcomp) dcount   <= dcount + 32'd1;
      if (stall) stallcnt <= stallcnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports; data has
// priority, bounded by MAX_DSTREAK. Optional counters: MEM_ARB_STATS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       stallcnt,
`endif
  output logic              mem_err
);

  // state | meaning
  // IDLE  | no grant, no RAM enables; arbitrate pending requests
  // IGNT  | RAM owned by instruction fetch until ACCESS/ERROR/drop
  // DGNT  | RAM owned by data port until ACCESS/ERROR/drop

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  arb_state_t state, state_nxt;
  logic [3:0] dstreak, dstreak_nxt;
  logic       dreq;
  logic       icomp;
  logic       dcomp;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
    end else begin
      state   <= state_nxt;
      dstreak <= dstreak_nxt;
    end
  end

  // Reset forces state to IDLE asynchronously, which alone zeroes every RAM
  // enable and read-data output while RST is high.
  always_comb begin
    state_nxt   = state;
    dstreak_nxt = dstreak;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;
    icomp       = 1'b0;
    dcomp       = 1'b0;
    mem_err     = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || dstreak < STREAK_MAX)) state_nxt = DGNT;
        else if (iREN)                                state_nxt = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == ACCESS) begin
            icomp       = 1'b1;
            iload       = ramload;
            dstreak_nxt = '0;
            state_nxt   = IDLE;
          end else if (ramstate == ERROR) begin
            mem_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DGNT: begin
        if (!dreq) begin
          state_nxt = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == ACCESS) begin
            dcomp     = 1'b1;
            state_nxt = IDLE;
            if (!dWEN) dload = ramload;
            if (dstreak < STREAK_MAX) dstreak_nxt = dstreak + 4'd1;
          end else if (ramstate == ERROR) begin
            mem_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign iwait = iREN & ~icomp;
  assign dwait = dreq & ~dcomp;

`ifdef MEM_ARB_STATS_EN
  arb_stats u_stats (
    .CLK      (CLK),
    .RST      (RST),
    .icomp    (icomp),
    .dcomp    (dcomp),
    .stall    (iwait | dwait),
    .icount   (icount),
    .dcount   (dcount),
    .stallcnt (stallcnt)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a grant/streak reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount, dcount, stallcnt;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD)) dut (
    .CLK      (bus.CLK),
    .RST      (bus.RST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .iload    (bus.iload),
    .iwait    (bus.iwait),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .dload    (bus.dload),
    .dwait    (bus.dwait),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .ramload  (bus.ramload),
    .ramstate (bus.ramstate),
`ifdef MEM_ARB_STATS_EN
    .icount   (icount),
    .dcount   (dcount),
    .stallcnt (stallcnt),
`endif
    .mem_err  (bus.mem_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial bus.CLK = 1'b0;
  always #5 bus.CLK = ~bus.CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner of the RAM (0 none, 1 ifetch, 2 data) and the
  // count of data completions since the last instruction completion.
  int          m_owner = 0, m_streak = 0, n_owner = 0, n_streak = 0;
  logic [31:0] m_ic = 0, m_dc = 0, m_sc = 0, n_ic = 0, n_dc = 0, n_sc = 0;
  logic        e_ren, e_wen, e_iw, e_dw, e_err, drq;
  logic [31:0] e_addr, e_store, e_il, e_dl;

  always @(negedge bus.CLK) begin
    drq = bus.dREN | bus.dWEN;
    e_ren = 0; e_wen = 0; e_err = 0;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    e_iw = bus.iREN; e_dw = drq;
    n_owner = m_owner; n_streak = m_streak;
    if (!bus.RST) begin
      if (m_owner == 0) begin
        if (drq && (!bus.iREN || m_streak < MAXD)) n_owner = 2;
        else if (bus.iREN) n_owner = 1;
      end else if (m_owner == 1 && bus.iREN) begin
        e_ren = 1; e_addr = bus.iaddr;
        if (bus.ramstate == ACCESS) begin
          e_iw = 0; e_il = bus.ramload; n_streak = 0; n_owner = 0;
        end else if (bus.ramstate == ERROR) begin
          e_err = 1; n_owner = 0;
        end
      end else if (m_owner == 2 && drq) begin
        e_addr = bus.daddr;
        if (bus.dWEN) begin e_wen = 1; e_store = bus.dstore; end
        else e_ren = 1;
        if (bus.ramstate == ACCESS) begin
          e_dw = 0; n_owner = 0;
          if (!bus.dWEN) e_dl = bus.ramload;
          n_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
        end else if (bus.ramstate == ERROR) begin
          e_err = 1; n_owner = 0;
        end
      end else begin
        n_owner = 0;
      end
    end
    n_ic = m_ic + ((bus.iREN && !e_iw) ? 32'd1 : 32'd0);
    n_dc = m_dc + ((drq && !e_dw) ? 32'd1 : 32'd0);
    n_sc = m_sc + ((e_iw || e_dw) ? 32'd1 : 32'd0);
    chk("ramREN",   {31'd0, bus.ramREN},  {31'd0, e_ren});
    chk("ramWEN",   {31'd0, bus.ramWEN},  {31'd0, e_wen});
    chk("ramaddr",  bus.ramaddr,          e_addr);
    chk("ramstore", bus.ramstore,         e_store);
    chk("iwait",    {31'd0, bus.iwait},   {31'd0, e_iw});
    chk("dwait",    {31'd0, bus.dwait},   {31'd0, e_dw});
    chk("iload",    bus.iload,            e_il);
    chk("dload",    bus.dload,            e_dl);
    chk("mem_err",  {31'd0, bus.mem_err}, {31'd0, e_err});
`ifdef MEM_ARB_STATS_EN
    chk("icount",   icount,   m_ic);
    chk("dcount",   dcount,   m_dc);
    chk("stallcnt", stallcnt, m_sc);
`endif
  end

  always @(posedge bus.CLK or posedge bus.RST) begin
    if (bus.RST) begin
      m_owner = 0; m_streak = 0; m_ic = 0; m_dc = 0; m_sc = 0;
    end else begin
      m_owner = n_owner; m_streak = n_streak; m_ic = n_ic; m_dc = n_dc; m_sc = n_sc;
    end
  end

  task automatic step();
    @(posedge bus.CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    bus.RST = 1;
    idle_inputs();
    step();
    step();
    bus.RST = 0;
  endtask

  int dcnt, icnt, ifirst, r;

  initial begin
    bus.RST = 1;
    idle_inputs();
    do_reset();
    #1;
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_state",  {30'd0, dut.state},  32'd0);

    // instruction only, two BUSY cycles then ACCESS
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY; bus.ramload = 32'h8C220004;
    #1 chk("i_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    step(); #1;
    chk("i_gnt_ren",  {31'd0, bus.ramREN}, 32'd1);
    chk("i_gnt_addr", bus.ramaddr, 32'h40);
    step(); #1;
    chk("i_busy_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    bus.ramstate = ACCESS;
    #1;
    chk("i_done_iwait", {31'd0, bus.iwait}, 32'd0);
    chk("i_done_iload", bus.iload, 32'h8C220004);
    step();
    idle_inputs();

    // simultaneous requests: data first, then instruction
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h100;
    bus.ramstate = ACCESS; bus.ramload = 32'h11223344;
    step(); #1;
    chk("sim_d_addr",  bus.ramaddr, 32'h100);
    chk("sim_d_dwait", {31'd0, bus.dwait}, 32'd0);
    chk("sim_d_dload", bus.dload, 32'h11223344);
    chk("sim_d_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    bus.dREN = 0;
    #1 chk("sim_streak1", {28'd0, dut.dstreak}, 32'd1);
    step(); #1;
    chk("sim_i_addr",  bus.ramaddr, 32'h44);
    chk("sim_i_iwait", {31'd0, bus.iwait}, 32'd0);
    step(); #1;
    chk("sim_streak0", {28'd0, dut.dstreak}, 32'd0);
    idle_inputs();

    // data streak bound with instruction pending
    do_reset();
    bus.iREN = 1; bus.dREN = 1; bus.ramstate = ACCESS;
    dcnt = 0; icnt = 0; ifirst = -1;
    for (int c = 0; c <= 10; c++) begin
      bus.ramload = $urandom;
      #1;
      if (!bus.dwait) dcnt++;
      if (!bus.iwait) begin icnt++; if (ifirst < 0) ifirst = c; end
      step();
    end
    chk("streak_dcnt",   dcnt, 32'd4);
    chk("streak_icnt",   icnt, 32'd1);
    chk("streak_ifirst", ifirst, 32'd9);
    #1 chk("streak_resume", {31'd0, bus.dwait}, 32'd0);
    idle_inputs();

    // write takes precedence over read
    do_reset();
    bus.dREN = 1; bus.dWEN = 1; bus.dstore = 32'hDEADBEEF; bus.daddr = 32'h200;
    bus.ramstate = BUSY;
    step(); #1;
    chk("wr_wen",   {31'd0, bus.ramWEN}, 32'd1);
    chk("wr_ren",   {31'd0, bus.ramREN}, 32'd0);
    chk("wr_store", bus.ramstore, 32'hDEADBEEF);
    chk("wr_addr",  bus.ramaddr, 32'h200);
    bus.ramstate = ACCESS;
    #1 chk("wr_done_dwait", {31'd0, bus.dwait}, 32'd0);
    step();
    idle_inputs();

    // ERROR during instruction grant, then retry
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
    step();
    bus.ramstate = ERROR;
    #1;
    chk("err_pulse", {31'd0, bus.mem_err}, 32'd1);
    chk("err_iwait", {31'd0, bus.iwait}, 32'd1);
    step();
    bus.ramstate = BUSY;
    #1;
    chk("err_idle_ren", {31'd0, bus.ramREN}, 32'd0);
    chk("err_idle_err", {31'd0, bus.mem_err}, 32'd0);
    step(); #1;
    chk("err_regrant", {31'd0, bus.ramREN}, 32'd1);
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
    #1;
    chk("err_retry_iwait", {31'd0, bus.iwait}, 32'd0);
    chk("err_retry_iload", bus.iload, 32'hCAFEF00D);
    step();
    idle_inputs();

    // reset mid data grant
    do_reset();
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    step(); #1;
    chk("rmid_ren_before", {31'd0, bus.ramREN}, 32'd1);
    bus.RST = 1;
    #1;
    chk("rmid_ren",     {31'd0, bus.ramREN}, 32'd0);
    chk("rmid_wen",     {31'd0, bus.ramWEN}, 32'd0);
    chk("rmid_dwait",   {31'd0, bus.dwait}, 32'd1);
    chk("rmid_state",   {30'd0, dut.state}, 32'd0);
    chk("rmid_dstreak", {28'd0, dut.dstreak}, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("rmid_icount", icount, 32'd0);
    chk("rmid_dcount", dcount, 32'd0);
    chk("rmid_stall",  stallcnt, 32'd0);
`endif
    step();
    do_reset();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      if (bus.RST) bus.RST = 0;
      else if ($urandom_range(0, 299) == 0) bus.RST = 1;
      if (bus.iREN) begin if ($urandom_range(0, 7) == 0) bus.iREN = 0; end
      else bus.iREN = $urandom_range(0, 1) == 1;
      if (bus.dREN || bus.dWEN) begin
        if ($urandom_range(0, 7) == 0) begin bus.dREN = 0; bus.dWEN = 0; end
      end else if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 2);
        bus.dREN = (r != 1);
        bus.dWEN = (r != 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
      end
      bus.ramload = $urandom;
      r = $urandom_range(0, 9);
      if (r < 3)       bus.ramstate = BUSY;
      else if (r == 3) bus.ramstate = FREE;
      else if (r == 4) bus.ramstate = ERROR;
      else             bus.ramstate = ACCESS;
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
